// File: rtl/main_mem_responder.sv
// Word-organised backing store: 512-bit block reads and 32-bit word writes, each answered by a one-cycle
// ready pulse after a programmable latency. Define MAIN_MEM_STATS_EN to add the rd_count/wr_count outputs.
module main_mem_responder #(
    parameter int MEM_WORDS     = 4096,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  mem_addr,
    input  logic [31:0]  mem_wdata,
    input  logic         mem_read_req,
    input  logic         mem_write_req,
    output logic [511:0] mem_rdata,
    output logic         mem_ready,
    output logic         mem_err,
`ifdef MAIN_MEM_STATS_EN
    output logic         mem_busy,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
`else
    output logic         mem_busy
`endif
);

    localparam int AW      = $clog2(MEM_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] RL_C  = CW'(READ_LATENCY);
    localparam logic [CW-1:0] WL_C  = CW'(WRITE_LATENCY);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [29:0]   LIMIT = 30'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_BURST,
        S_RD_DONE,
        S_WR_WAIT,
        S_WR_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_beat;
    logic            r_err_flag;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [479:0]    r_block;
    logic [511:0]    r_rdata;
    logic            r_ready;
    logic            r_err;
    logic            r_busy;
    logic [31:0]     r_mem [MEM_WORDS];

    logic [29:0]     w_rd_idx;
    logic [29:0]     w_wr_idx;
    logic            w_rd_oor;
    logic            w_wr_oor;
    logic [AW-1:0]   w_beat_addr;
    logic [31:0]     w_beat_word;
    logic            w_done_nxt;
    logic            w_commit;
    logic            w_unused_addr;

    assign w_rd_idx      = {mem_addr[31:6], 4'b0000};
    assign w_wr_idx      = mem_addr[31:2];
    assign w_rd_oor      = (w_rd_idx >= LIMIT);
    assign w_wr_oor      = (w_wr_idx >= LIMIT);
    assign w_unused_addr = ^mem_addr[1:0];
    // Out-of-range reads return zeros and never touch the array.
    assign w_beat_addr   = r_idx + AW'(r_beat);
    assign w_beat_word   = r_err_flag ? 32'h0 : r_mem[w_beat_addr];
    assign w_commit      = (r_state == S_WR_WAIT) && (r_cnt == ONE_C) && !r_err_flag;

    always_comb begin
        w_next     = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_read_req)       w_next = S_RD_WAIT;
                else if (mem_write_req) w_next = S_WR_WAIT;
            end
            S_RD_WAIT:  if (r_cnt == ONE_C)  w_next = S_RD_BURST;
            S_RD_BURST: if (r_beat == 4'd15) w_next = S_RD_DONE;
            S_RD_DONE:  w_next = S_IDLE;
            S_WR_WAIT:  if (r_cnt == ONE_C)  w_next = S_WR_DONE;
            S_WR_DONE:  w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        w_done_nxt = (w_next == S_RD_DONE) || (w_next == S_WR_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_beat     <= '0;
            r_err_flag <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_ready <= w_done_nxt;
            r_err   <= w_done_nxt && r_err_flag;
            case (r_state)
                S_IDLE: begin
                    if (mem_read_req) begin
                        r_err_flag <= w_rd_oor;
                        r_cnt      <= RL_C;
                    end else if (mem_write_req) begin
                        r_err_flag <= w_wr_oor;
                        r_cnt      <= WL_C;
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == ONE_C) r_beat <= '0;
                    else                r_cnt  <= r_cnt - ONE_C;
                end
                S_RD_BURST: begin
                    r_beat <= r_beat + 4'd1;
                    // Last beat goes straight into the output so data is valid with ready.
                    if (r_beat == 4'd15) r_rdata <= {w_beat_word, r_block};
                end
                S_WR_WAIT: begin
                    if (r_cnt != ONE_C) r_cnt <= r_cnt - ONE_C;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && (mem_read_req || mem_write_req)) begin
            r_idx   <= mem_read_req ? w_rd_idx[AW-1:0] : w_wr_idx[AW-1:0];
            r_wdata <= mem_wdata;
        end
        if (r_state == S_RD_BURST && r_beat != 4'd15) begin
            r_block[{r_beat, 5'b00000} +: 32] <= w_beat_word;
        end
        if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_next == S_RD_DONE && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            if (w_next == S_WR_DONE && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

    assign mem_rdata = r_rdata;
    assign mem_ready = r_ready;
    assign mem_err   = r_err;
    assign mem_busy  = r_busy;

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Main-memory side of the cache-controller/main-memory interface.
- Accepts single-cycle block-read and word-write request pulses from the cache controller. Returns a 512-bit block, or a write acknowledgement, with a one-cycle ready pulse after a programmable latency.
- Synthesizable word-organised storage. Used as the backing store in system simulation and FPGA bring-up.

Parameters:
- MEM_WORDS, 4096, storage depth in 32-bit words; multiple of 16.
- READ_LATENCY, 4, access-delay cycles before a read burst starts; must be >= 1.
- WRITE_LATENCY, 2, delay cycles before a write commits; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_addr  input  32  byte address; reads use bits [31:6], writes use bits [31:2].
- mem_wdata  input  32  write data word.
- mem_read_req  input  1  block-read request, sampled only in IDLE.
- mem_write_req  input  1  word-write request, sampled only in IDLE.
- mem_rdata  output  512  block read data; word w occupies bits [w*32 +: 32].
- mem_ready  output  1  one-cycle completion pulse for both reads and writes.
- mem_err  output  1  asserted together with mem_ready when the access was out of range.
- mem_busy  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: mem_rdata=0, mem_ready=0, mem_err=0, mem_busy=0, state=IDLE, counters=0. The storage array is not cleared.
- States: IDLE, RD_WAIT, RD_BURST, RD_DONE, WR_WAIT, WR_DONE.
- IDLE:
  - read_req=1 -> latch block base word index {addr[31:6],4'b0}, load delay counter with READ_LATENCY, go to RD_WAIT.
  - write_req=1 (read_req=0) -> latch word index addr[31:2] and wdata, load delay counter with WRITE_LATENCY, go to WR_WAIT.
  - Both requests high -> read takes priority and the write is dropped silently.
- In-range check is done at latch: index < MEM_WORDS (reads check the base index; MEM_WORDS is a multiple of 16, so the whole block is then in range). The result is held as an err flag for the transaction.
- RD_WAIT: decrement the counter each cycle; when it reaches 1, clear the beat counter and go to RD_BURST.
- RD_BURST: 16 cycles. Beat b (0..15) writes storage[base+b], or 0 if out of range, into the internal block register slice b. After beat 15, go to RD_DONE.
- RD_DONE: mem_rdata <= block register at entry. mem_ready=1 for exactly this cycle; mem_err=err flag. Next state IDLE.
- mem_rdata is stable from the RD_DONE cycle until the next RD_DONE; it is not disturbed by writes.
- WR_WAIT: count down WRITE_LATENCY cycles. On the last cycle, commit storage[idx] <= wdata, unless err is set, in which case the write is suppressed. Go to WR_DONE.
- WR_DONE: mem_ready=1 for one cycle, mem_err=err flag, then IDLE.
- Latency from the request-sampling edge to the mem_ready-high cycle: read = READ_LATENCY+17 cycles; write = WRITE_LATENCY+1 cycles.
- Requests arriving while mem_busy=1 are ignored: not queued, no response.
- Back-to-back: a request present in the cycle after mem_ready is accepted, because IDLE is re-entered then.
- Read-after-write to the same word returns the new data, since the write commits before WR_DONE.
- Reset mid-transaction: aborts immediately; any uncommitted write is lost and no mem_ready is issued.
- mem_ready, mem_err and mem_busy are registered outputs; none is combinationally derived from the request inputs.

Optional Feature:
- Macro MAIN_MEM_STATS_EN.
- When defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0], both reset to 0.
  - Each increments by 1 on the mem_ready cycle of a completed read or write respectively.
  - Each saturates at 16'hFFFF.
  - Out-of-range accesses are counted too.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Write then read, in range: write addr 0x0000_0044, data 0xDEAD_BEEF.
  - Write: mem_ready high 3 cycles after the request, mem_err=0.
  - Read addr 0x0000_0040: mem_ready 21 cycles after the request; mem_rdata[63:32]=0xDEADBEEF, other words unchanged.
- Unaligned read: read addr 0x0000_007F -> same block as 0x40. The returned block is identical, proving low-bit masking.
- Out-of-range access, with MEM_WORDS=4096 (byte 0x4000 and above is out of range):
  - Read 0x0000_4000 -> mem_ready and mem_err high together, mem_rdata=0.
  - Write 0x0000_4000 -> mem_err=1, and storage is unchanged on readback of the aliased low address 0x0.
- Busy drop: issue a read, then pulse write_req 5 cycles later -> that write gets no ready pulse and is never committed. Only one mem_ready, for the read.
- Reset mid-op: assert rst_n=0 during RD_BURST beat 7.
  - All outputs go to 0 asynchronously; state IDLE.
  - A subsequent read completes normally with the full 21-cycle latency.
- Simultaneous requests: read_req=write_req=1 at addr 0x80 -> read is serviced after 21 cycles; a later read of 0x80 shows the original data. With MAIN_MEM_STATS_EN defined, rd_count=2 and wr_count=0.
